adder_share_arb: RTL and testbench
==================================

# adder_share_arb

Round-robin arbiter sharing one 64-bit ripple adder (`bit64_adder`) between up to NREQ requesters: fetch PC increment, execute ALU add, stack-pointer update, branch target. It accepts one add per cycle through a valid/ready handshake. It registers the sum plus signed condition flags into a single response slot tagged with the requester ID. The slot honours downstream backpressure. The block sits between decode/execute stage requesters and the shared adder datapath.

## Interface
- NREQ, 4: number of requesters, 2..8
- IDW, $clog2(NREQ): requester ID width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*64  operand A, requester i at bits [64i+63:64i]
- req_b  in  NREQ*64  operand B, same packing
- req_lock  in  NREQ  keep grant for next request (only with ADDER_ARB_LOCK_EN)
- req_ready  out  NREQ  one-hot grant/accept, combinational
- rsp_valid  out  1  response slot full
- rsp_id  out  IDW  requester that owns the response
- rsp_sum  out  64  A+B, two's complement, wraps mod 2^64
- rsp_of  out  1  signed overflow (carry into bit 63 XOR carry out of bit 63)
- rsp_zf  out  1  rsp_sum == 0
- rsp_sf  out  1  rsp_sum[63]
- rsp_ready  in  1  consumer accepts response

## Operation
- Accept condition: `can_issue = !rsp_valid || rsp_ready`. When it is low, req_ready is all zero.
- Grant: among asserted req_valid, the first index strictly after `last_ptr`, searching circularly. req_ready[g] = 1 for that index only. A transfer happens when req_valid[g] && req_ready[g].
- On transfer:
  - operands of g drive the adder
  - the registered slot loads sum, flags and id=g, and sets rsp_valid
  - last_ptr <= g
- Slot drains when rsp_valid && rsp_ready with no new transfer. rsp_valid then clears; other slot fields hold their last value.
- Drain and new transfer in the same cycle: the slot is overwritten and rsp_valid stays 1. This gives full throughput.
- Slot FSM, implicit in rsp_valid:
  - EMPTY → FULL on transfer
  - FULL → FULL on drain+transfer, or on stall (rsp_ready=0)
  - FULL → EMPTY on drain only
- Requesters may drop req_valid before grant. A request that is not granted has no side effects.
- Operand changes while not granted are allowed. The values sampled are those in the transfer cycle.
- No requester valid: no transfer, last_ptr unchanged.

## Timing
- Latency: transfer in cycle T → rsp_valid=1 with result in cycle T+1.
- Throughput: 1 add/cycle while rsp_ready=1.
- Response outputs are registered. req_ready is combinational from req_valid, last_ptr and rsp_valid/rsp_ready. There is no combinational path from req_a/req_b to outputs.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_of=0, rsp_zf=0, rsp_sf=0
  - last_ptr=NREQ-1, so requester 0 wins first
  - lock_owner cleared
- Reset mid-operation: a pending slot is discarded without handshake. Requesters must reissue.
- Fairness: a continuously requesting agent waits at most NREQ-1 transfers (without lock).

## Configuration
- `ADDER_ARB_LOCK_EN` defined:
  - A transfer with req_lock[g]=1 sets lock_owner=g, locked=1.
  - While locked, only g may be granted, even if others request.
  - Lock clears on a transfer from g with req_lock=0, or when g drops req_valid while can_issue=1.
  - Used for multi-word address sequences.
- Undefined: req_lock is ignored (port kept), no lock state, pure round-robin.

## Structure
- Package `adder_arb_pkg`:
  - `localparam DW = 64`
  - typedef `adder_flags_t` {of, zf, sf}
  - function `rr_next(valid, last_ptr)` reference model for verification
- Sub-module `rr_picker`: combinational rotate–priority-encode–rotate-back. Inputs valid[NREQ], last_ptr, mask_en/mask_idx for lock. Outputs one-hot grant and encoded index.
- One instance of `bit64_adder`, operands from an NREQ:1 mux on the encoded grant index.

## Test plan
- Single request: req0 with A=5, B=7 → req_ready[0] same cycle; next cycle rsp_valid=1, id=0, sum=12, of=0, zf=0, sf=0.
- Overflow and flags:
  - A=0x7FFF_FFFF_FFFF_FFFF, B=1 → sum=0x8000_0000_0000_0000, of=1, sf=1, zf=0
  - A=-1, B=1 → sum=0, zf=1, of=0
- Round-robin: req0..3 all held valid with rsp_ready=1 → grant order 0,1,2,3,0; responses back-to-back with ids matching, no bubble.
- Backpressure: slot full, rsp_ready=0 for 3 cycles → req_ready all 0 and slot stable. rsp_ready=1 → drain plus new grant in the same cycle, rsp_valid stays 1.
- Reset mid-stream: rst_n asserted with rsp_valid=1 → all outputs 0 immediately. After release, the first grant goes to requester 0 when all request.
- Lock (ADDER_ARB_LOCK_EN): req2 issues with lock=1 while req0 and req1 request → three consecutive grants to 2. Lock=0 on the third → next grant to 3 if it requests, else 0.

Source files
------------

// File: rtl/adder_share_arb_pkg.sv
// Shared types and constants for the adder-sharing arbiter.
// rr_next is a plain round-robin reference used when checking the picker.
package adder_arb_pkg;

  localparam int DW = 64;

  typedef struct packed {
    logic of;
    logic zf;
    logic sf;
  } adder_flags_t;

  // Returns the first valid index strictly after last_ptr, searching circularly; -1 if none.
  function automatic int rr_next(input logic [7:0] valid, input int nreq, input int last_ptr);
    int idx;
    for (int k = 1; k <= nreq; k++) begin
      idx = (last_ptr + k) % nreq;
      if (valid[idx[2:0]]) return idx;
    end
    return -1;
  endfunction

endpackage

// File: rtl/adder_share_arb_if.sv
// Request/response bundle between the requesters, the arbiter and the result consumer.
// The slave modport is the arbiter's view.
interface adder_share_arb_if
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_sum;
  logic               rsp_of;
  logic               rsp_zf;
  logic               rsp_sf;
  logic               rsp_ready;

  modport master (
    output req_valid, req_a, req_b, req_lock, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_of, rsp_zf, rsp_sf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_lock, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_of, rsp_zf, rsp_sf
  );

endinterface

// File: rtl/adder_share_arb_bit64_adder.sv
// 64-bit ripple-carry adder exposing the carry into and out of the MSB
// so the caller can derive signed overflow.
module bit64_adder
  import adder_arb_pkg::*;
(
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_sum,
  output logic          o_c_msb_in,
  output logic          o_c_out
);

  always_comb begin
    logic c;
    c          = 1'b0;
    o_sum      = '0;
    o_c_msb_in = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (i == DW - 1) o_c_msb_in = c;
      o_sum[i] = i_a[i] ^ i_b[i] ^ c;
      c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
    end
    o_c_out = c;
  end

endmodule

// File: rtl/adder_share_arb_rr_picker.sv
// Combinational round-robin picker: rotate so the search starts after last_ptr,
// priority-encode the lowest set bit, then rotate the index back.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDW-1:0]  i_last_ptr,
  input  logic            i_mask_en,
  input  logic [IDW-1:0]  i_mask_idx,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [NREQ-1:0] w_valid;
  logic [NREQ-1:0] w_rot;
  logic [IDW:0]    w_start;
  logic [IDW:0]    w_off;
  logic [IDW:0]    w_sum;

  // A held lock narrows the candidates to the lock owner alone.
  always_comb begin
    w_valid = i_valid;
    if (i_mask_en) w_valid = i_valid & (NREQ'(1) << i_mask_idx);
  end

  assign w_start = {1'b0, i_last_ptr} + (IDW+1)'(1);
  assign w_rot   = (w_valid >> w_start) | (w_valid << ((IDW+1)'(NREQ) - w_start));

  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = (IDW+1)'(i);
    end
  end

  assign w_sum   = w_start + w_off;
  assign o_idx   = (w_sum >= (IDW+1)'(NREQ)) ? (w_sum[IDW-1:0] - IDW'(NREQ)) : w_sum[IDW-1:0];
  assign o_any   = |w_valid;
  assign o_grant = o_any ? (NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one 64-bit adder, with a single registered response slot.
// Define ADDER_ARB_LOCK_EN to let a requester hold the grant across consecutive adds.
module adder_share_arb
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic              clk,
  input logic              rst_n,
  adder_share_arb_if.slave io_bus
);

  logic            w_can_issue;
  logic            w_any;
  logic            w_xfer;
  logic            w_mask_en;
  logic [IDW-1:0]  w_mask_idx;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic [DW-1:0]   w_op_a;
  logic [DW-1:0]   w_op_b;
  logic [DW-1:0]   w_sum;
  logic            w_c_msb_in;
  logic            w_c_out;
  adder_flags_t    w_flags;

  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [DW-1:0]   r_rsp_sum;
  adder_flags_t    r_flags;
  logic [IDW-1:0]  r_last_ptr;

  assign w_can_issue = !r_rsp_valid || io_bus.rsp_ready;
  assign w_xfer      = w_can_issue && w_any;

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .i_valid    (io_bus.req_valid),
    .i_last_ptr (r_last_ptr),
    .i_mask_en  (w_mask_en),
    .i_mask_idx (w_mask_idx),
    .o_grant    (w_grant),
    .o_idx      (w_idx),
    .o_any      (w_any)
  );

  assign io_bus.req_ready = w_can_issue ? w_grant : '0;

`ifdef ADDER_ARB_LOCK_EN
  logic           r_locked;
  logic [IDW-1:0] r_lock_owner;

  // The owner releases by issuing without lock, or by withdrawing while the slot could accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked     <= 1'b0;
      r_lock_owner <= '0;
    end else if (w_xfer) begin
      r_locked     <= io_bus.req_lock[w_idx];
      r_lock_owner <= w_idx;
    end else if (r_locked && w_can_issue && !io_bus.req_valid[r_lock_owner]) begin
      r_locked <= 1'b0;
    end
  end

  assign w_mask_en  = r_locked;
  assign w_mask_idx = r_lock_owner;
`else
  assign w_mask_en  = 1'b0;
  assign w_mask_idx = '0;
`endif

  assign w_op_a = io_bus.req_a[{w_idx, {$clog2(DW){1'b0}}} +: DW];
  assign w_op_b = io_bus.req_b[{w_idx, {$clog2(DW){1'b0}}} +: DW];

  bit64_adder u_adder (
    .i_a        (w_op_a),
    .i_b        (w_op_b),
    .o_sum      (w_sum),
    .o_c_msb_in (w_c_msb_in),
    .o_c_out    (w_c_out)
  );

  assign w_flags = '{of: (w_c_msb_in ^ w_c_out), zf: (w_sum == '0), sf: w_sum[DW-1]};

  // A transfer always overwrites the slot, so a drain and a new add in one cycle keep it full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_flags     <= '0;
      r_last_ptr  <= IDW'(NREQ - 1);
    end else if (w_xfer) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_idx;
      r_rsp_sum   <= w_sum;
      r_flags     <= w_flags;
      r_last_ptr  <= w_idx;
    end else if (io_bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_id    = r_rsp_id;
  assign io_bus.rsp_sum   = r_rsp_sum;
  assign io_bus.rsp_of    = r_flags.of;
  assign io_bus.rsp_zf    = r_flags.zf;
  assign io_bus.rsp_sf    = r_flags.sf;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed and random checks of adder_share_arb against a behavioural arbiter/slot model.
// Lock scenarios are exercised only when ADDER_ARB_LOCK_EN is defined.
module tb_adder_share_arb;
  import adder_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [DW-1:0] opA [NREQ];
  logic [DW-1:0] opB [NREQ];

  bit            mValid;
  int            mId;
  logic [DW-1:0] mSum;
  bit            mOf, mZf, mSf;
  int            lastGrant;
  bit            lockOn;
  int            lockOwner;

  adder_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  adder_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkRsp(input string tag);
    checkOutput({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(mValid));
    checkOutput({tag, ".rsp_id"},    64'(bus.rsp_id),    64'(mId));
    checkOutput({tag, ".rsp_sum"},   bus.rsp_sum,        mSum);
    checkOutput({tag, ".rsp_of"},    64'(bus.rsp_of),    64'(mOf));
    checkOutput({tag, ".rsp_zf"},    64'(bus.rsp_zf),    64'(mZf));
    checkOutput({tag, ".rsp_sf"},    64'(bus.rsp_sf),    64'(mSf));
  endtask

  // Which requester should win this cycle, or -1 if nobody may transfer.
  function automatic int modelGrant(input logic [NREQ-1:0] v, input bit rr);
    int idx;
    if (mValid && !rr) return -1;
    if (lockOn) return v[lockOwner] ? lockOwner : -1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (lastGrant + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic applyReset(input string tag);
    rst_n = 1'b0;
    #1;
    mValid = 0; mId = 0; mSum = '0; mOf = 0; mZf = 0; mSf = 0;
    lastGrant = NREQ - 1; lockOn = 0; lockOwner = 0;
    checkRsp(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drive one cycle of requests, check the grant before the edge and the slot after it.
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] lk, input bit rr,
                               input string tag);
    int            g;
    bit            canIssue;
    logic [NREQ-1:0] expReady;
    logic [DW-1:0] a, b, s;
    bus.req_valid = v;
    bus.req_lock  = lk;
    bus.rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*DW +: DW] = opA[i];
      bus.req_b[i*DW +: DW] = opB[i];
    end
    #1;
    canIssue = !mValid || rr;
    g = modelGrant(v, rr);
    expReady = (g >= 0) ? (NREQ'(1) << g) : '0;
    checkOutput({tag, ".req_ready"}, 64'(bus.req_ready), 64'(expReady));
    @(posedge clk);
    if (g >= 0) begin
      a = opA[g]; b = opB[g]; s = a + b;
      mValid = 1; mId = g; mSum = s;
      mOf = (a[63] == b[63]) && (s[63] != a[63]);
      mZf = (s == 64'd0);
      mSf = s[63];
      lastGrant = g;
`ifdef ADDER_ARB_LOCK_EN
      lockOn = lk[g];
      lockOwner = g;
`endif
    end else begin
      if (rr) mValid = 0;
`ifdef ADDER_ARB_LOCK_EN
      if (lockOn && canIssue && !v[lockOwner]) lockOn = 0;
`endif
    end
    #1;
    checkRsp(tag);
  endtask

  function automatic logic [DW-1:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return 64'h0;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end
    @(posedge clk);
    #1;
    applyReset("reset");

    opA[0] = 64'd5; opB[0] = 64'd7;
    applyStimulus(4'b0001, 4'b0000, 1'b1, "single");
    checkOutput("single.sum_const", bus.rsp_sum, 64'd12);
    applyStimulus(4'b0000, 4'b0000, 1'b1, "drain");

    opA[1] = 64'h7FFF_FFFF_FFFF_FFFF; opB[1] = 64'd1;
    applyStimulus(4'b0010, 4'b0000, 1'b1, "ovf");
    checkOutput("ovf.of_const", 64'(bus.rsp_of), 64'd1);
    opA[2] = 64'hFFFF_FFFF_FFFF_FFFF; opB[2] = 64'd1;
    applyStimulus(4'b0100, 4'b0000, 1'b1, "zero");
    checkOutput("zero.zf_const", 64'(bus.rsp_zf), 64'd1);

    opA[3] = 64'd100; opB[3] = 64'd200;
    applyStimulus(4'b1000, 4'b0000, 1'b1, "pre_rst");
    applyReset("mid_reset");

    for (int i = 0; i < NREQ; i++) begin
      opA[i] = randOperand();
      opB[i] = randOperand();
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 4'b0000, 1'b1, "rr");
      checkOutput("rr.order", 64'(bus.rsp_id), 64'(k % NREQ));
    end

    for (int k = 0; k < 3; k++) applyStimulus(4'b1111, 4'b0000, 1'b0, "bp_stall");
    applyStimulus(4'b1111, 4'b0000, 1'b1, "bp_release");
    checkOutput("bp_release.id", 64'(bus.rsp_id), 64'd1);

`ifdef ADDER_ARB_LOCK_EN
    applyReset("lock_reset");
    applyStimulus(4'b0001, 4'b0000, 1'b1, "lock_pre0");
    applyStimulus(4'b0010, 4'b0000, 1'b1, "lock_pre1");
    applyStimulus(4'b0111, 4'b0100, 1'b1, "lock_a");
    checkOutput("lock_a.id", 64'(bus.rsp_id), 64'd2);
    applyStimulus(4'b0111, 4'b0100, 1'b1, "lock_b");
    checkOutput("lock_b.id", 64'(bus.rsp_id), 64'd2);
    applyStimulus(4'b0111, 4'b0000, 1'b1, "lock_c");
    checkOutput("lock_c.id", 64'(bus.rsp_id), 64'd2);
    applyStimulus(4'b1111, 4'b0000, 1'b1, "lock_after");
    checkOutput("lock_after.id", 64'(bus.rsp_id), 64'd3);
`endif

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        opA[i] = randOperand();
        opB[i] = randOperand();
      end
      applyStimulus(NREQ'($urandom()), NREQ'($urandom()), ($urandom_range(0, 3) != 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
